// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared widths, default halt opcode and sequencer states
package instr_fetch_pkg;

  localparam int FUNC_W = 4;
  localparam int VAL_W  = 4;
  localparam int ADDR_W = 4;
  localparam int WORD_W = FUNC_W + VAL_W;
  localparam int DEPTH  = 1 << ADDR_W;

  localparam logic [FUNC_W-1:0] HALT_FUNC_DEF = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

endpackage

// File: rtl/instr_rom.sv
// rtl/instr_rom.sv - 16x8 program store, synchronous write, combinational read
// Ports:
//   clk, rst_n : clock, async active-low reset (clears every word)
//   we         : write strobe, word written at rising edge
//   waddr/wdata: write address and word
//   raddr/rdata: combinational read port
module instr_rom
  import instr_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - program store plus fetch/issue sequencer with ready handshake
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   start               : run from address 0 (IDLE/HALT only)
//   prog_we/addr/data   : program write port (IDLE/HALT only)
//   ctrl_ready          : downstream accepts the presented instruction
//   instr_valid/func/val: issued instruction
//   pc                  : current program address
//   busy, halted        : FETCH/ISSUE and HALT status
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [FUNC_W-1:0] HALT_FUNC = HALT_FUNC_DEF,
  parameter bit                WRAP      = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [WORD_W-1:0] prog_data,
  input  logic              ctrl_ready,
  output logic              instr_valid,
  output logic [FUNC_W-1:0] func,
  output logic [VAL_W-1:0]  val,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted
);

  state_t            state, state_nxt;
  logic              pc_clear, pc_inc, load_instr;
  logic              parked;
  logic [WORD_W-1:0] rom_rdata;

  // The store is only writable while the sequencer is parked, so a running
  // program can never be modified underneath itself.
  assign parked = (state == ST_IDLE) || (state == ST_HALT);

  instr_rom u_rom (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (prog_we && parked),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc),
    .rdata (rom_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_clear   = 1'b0;
    pc_inc     = 1'b0;
    load_instr = 1'b0;
    case (state)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          pc_clear  = 1'b1;
          state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        // A halt word is never presented downstream.
        if (rom_rdata[WORD_W-1:VAL_W] == HALT_FUNC) begin
          state_nxt = ST_HALT;
        end else begin
          load_instr = 1'b1;
          state_nxt  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (ctrl_ready) begin
          if ((pc == {ADDR_W{1'b1}}) && !WRAP) begin
            state_nxt = ST_HALT;
          end else begin
            pc_inc    = 1'b1;
            state_nxt = ST_FETCH;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (pc_clear) begin
      pc <= '0;
    end else if (pc_inc) begin
      pc <= pc + ADDR_W'(1);
    end
  end

  // func/val are registered at FETCH only, so ctrl_ready never reaches them
  // combinationally and they hold the last issued word outside ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      func <= '0;
      val  <= '0;
    end else if (load_instr) begin
      func <= rom_rdata[WORD_W-1:VAL_W];
      val  <= rom_rdata[VAL_W-1:0];
    end
  end

  // Decoded straight from the state register so reset removes them at once.
  assign instr_valid = (state == ST_ISSUE);
  assign busy        = (state == ST_FETCH) || (state == ST_ISSUE);
  assign halted      = (state == ST_HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch (WRAP=0 and WRAP=1 instances)
module tb_instr_fetch;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       prog_we = 1'b0;
  logic [3:0] prog_addr = 4'd0;
  logic [7:0] prog_data = 8'd0;
  logic       ctrl_ready = 1'b0;

  logic [1:0] iv, bz, hl;
  logic [3:0] f [2];
  logic [3:0] v [2];
  logic [3:0] p [2];

  int checks = 0;
  int errors = 0;

  logic [7:0]  mmem [16];
  logic [11:0] q0 [$];
  logic [11:0] q1 [$];
  int          idx  [2];
  int          vcyc [2];

  always #5 clk = ~clk;

  instr_fetch #(.HALT_FUNC(4'hF), .WRAP(1'b0)) dut_nowrap (
    .clk(clk), .rst_n(rst_n), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .ctrl_ready(ctrl_ready),
    .instr_valid(iv[0]), .func(f[0]), .val(v[0]), .pc(p[0]),
    .busy(bz[0]), .halted(hl[0])
  );

  instr_fetch #(.HALT_FUNC(4'hF), .WRAP(1'b1)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .ctrl_ready(ctrl_ready),
    .instr_valid(iv[1]), .func(f[1]), .val(v[1]), .pc(p[1]),
    .busy(bz[1]), .halted(hl[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walk the program from address 0 and list the {func,val,pc} issues it makes.
  function automatic void build(input int k, input int cap, input bit wrap);
    int pcm = 0;
    for (int n = 0; n < cap; n++) begin
      logic [7:0]  w;
      logic [11:0] e;
      w = mmem[pcm];
      if (w[7:4] == 4'hF) break;
      e = {w, 4'(pcm)};
      if (k == 0) q0.push_back(e); else q1.push_back(e);
      if (pcm == 15 && !wrap) break;
      pcm = (pcm + 1) % 16;
    end
  endfunction

  // Every cycle an instruction is presented it must equal the model's next issue.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        idx[k]  = 0;
        vcyc[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (iv[k]) begin
          int          sz;
          logic [11:0] head;
          vcyc[k]++;
          checks++;
          sz = (k == 0) ? q0.size() : q1.size();
          if (idx[k] >= sz) begin
            errors++;
            $display("FAIL unexpected_issue inst%0d act=%0h exp=none", k, {f[k], v[k], p[k]});
          end else begin
            head = (k == 0) ? q0[idx[k]] : q1[idx[k]];
            if ({f[k], v[k], p[k]} !== head) begin
              errors++;
              $display("FAIL issue inst%0d act=%0h exp=%0h", k, {f[k], v[k], p[k]}, head);
            end
          end
          if (ctrl_ready) idx[k]++;
        end
      end
    end
  end

  task automatic clear_model();
    q0.delete();
    q1.delete();
    for (int i = 0; i < 16; i++) mmem[i] = 8'h00;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_model();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    prog_addr = a;
    prog_data = d;
    prog_we   = 1'b1;
    mmem[a]   = d;
    tick();
    prog_we   = 1'b0;
  endtask

  task automatic go(input int cap);
    build(0, cap, 1'b0);
    build(1, cap, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_halt(input int k, input int maxc);
    int n = 0;
    while (!hl[k] && n < maxc) begin
      tick();
      n++;
    end
    chk($sformatf("halt_reached_inst%0d", k), hl[k], 1);
  endtask

  initial begin
    clear_model();
    #2;
    for (int k = 0; k < 2; k++) begin
      chk("rst_valid", iv[k], 0);
      chk("rst_pc", p[k], 0);
      chk("rst_func_val", {f[k], v[k]}, 0);
      chk("rst_busy_halted", {bz[k], hl[k]}, 0);
    end
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    for (int k = 0; k < 2; k++) chk("idle_wait_start", {bz[k], hl[k]}, 0);

    // Two issues, then halt word at address 2.
    wr(4'd0, 8'h13);
    wr(4'd1, 8'h25);
    wr(4'd2, 8'hF0);
    ctrl_ready = 1'b1;
    go(40);
    chk("model_len", q0.size(), 2);
    chk("model_w0", q0[0], 12'h130);
    chk("model_w1", q0[1], 12'h251);
    for (int k = 0; k < 2; k++) chk("lat_fetch", {iv[k], bz[k]}, 2'b01);
    tick();
    for (int k = 0; k < 2; k++) chk("lat_issue", {iv[k], f[k], v[k]}, 9'h113);
    wait_halt(0, 20);
    for (int k = 0; k < 2; k++) begin
      chk("prog3_halted", hl[k], 1);
      chk("prog3_pc", p[k], 2);
      chk("prog3_issues", idx[k], 2);
      chk("prog3_retain", {iv[k], f[k], v[k]}, 9'h025);
    end

    // Stall: five cycles without ready, then the handshake.
    do_reset();
    wr(4'd0, 8'h17);
    wr(4'd1, 8'hF0);
    ctrl_ready = 1'b0;
    go(40);
    chk("model_stall", q0[0], 12'h170);
    tick();
    repeat (5) tick();
    ctrl_ready = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) chk("stall_pc_after", p[k], 1);
    wait_halt(0, 10);
    for (int k = 0; k < 2; k++) begin
      chk("stall_valid_cycles", vcyc[k], 6);
      chk("stall_issues", idx[k], 1);
      chk("stall_halt_pc", p[k], 1);
    end

    // All 16 words issue; WRAP=0 stops at 15, WRAP=1 wraps to 0.
    do_reset();
    for (int a = 0; a < 16; a++) wr(4'(a), 8'h11);
    ctrl_ready = 1'b1;
    go(40);
    chk("model_nowrap_len", q0.size(), 16);
    chk("model_nowrap_last", q0[15], 12'h11F);
    chk("model_wrap_17th", q1[16], 12'h110);
    wait_halt(0, 80);
    chk("nowrap_issues", idx[0], 16);
    chk("nowrap_pc", p[0], 15);
    chk("wrap_not_halted", hl[1], 0);
    chk("wrap_pc_0", p[1], 0);
    chk("wrap_issues_16", idx[1], 16);
    repeat (6) tick();
    chk("wrap_continues", idx[1] > 16, 1);

    // Asynchronous reset in the middle of a stalled issue.
    do_reset();
    for (int a = 0; a < 16; a++) wr(4'(a), 8'h11);
    ctrl_ready = 1'b1;
    go(40);
    repeat (6) tick();
    ctrl_ready = 1'b0;
    for (int n = 0; n < 4 && !iv[0]; n++) tick();
    chk("pre_rst_issue", {iv[0], f[0], p[0]}, 9'h113);
    #2;
    rst_n = 1'b0;
    clear_model();
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("arst_valid", iv[k], 0);
      chk("arst_pc_func_val", {p[k], f[k], v[k]}, 0);
      chk("arst_busy_halted", {bz[k], hl[k]}, 0);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) chk("arst_idle", bz[k], 0);
    ctrl_ready = 1'b1;
    go(40);
    chk("model_zero", q0[5], 12'h005);
    wait_halt(0, 80);
    chk("cleared_issues", idx[0], 16);
    chk("cleared_pc", p[0], 15);

    // Writes ignored while running, honoured in HALT (same cycle as start).
    do_reset();
    wr(4'd0, 8'h31);
    wr(4'd1, 8'hF0);
    ctrl_ready = 1'b0;
    go(40);
    tick();
    prog_addr = 4'd0;
    prog_data = 8'h42;
    prog_we   = 1'b1;
    start     = 1'b1;
    tick();
    prog_we   = 1'b0;
    start     = 1'b0;
    for (int k = 0; k < 2; k++) chk("issue_ignores_start", {iv[k], f[k], v[k], p[k]}, 13'h1310);
    ctrl_ready = 1'b1;
    tick();
    wait_halt(0, 10);
    for (int k = 0; k < 2; k++) chk("halt_pc_1", p[k], 1);
    go(40);
    wait_halt(0, 10);
    for (int k = 0; k < 2; k++) chk("store_unchanged_issues", idx[k], 2);
    prog_addr = 4'd0;
    prog_data = 8'h42;
    prog_we   = 1'b1;
    mmem[0]   = 8'h42;
    go(40);
    prog_we   = 1'b0;
    tick();
    wait_halt(0, 10);
    for (int k = 0; k < 2; k++) begin
      chk("halt_write_issues", idx[k], 3);
      chk("halt_write_func_val", {f[k], v[k]}, 8'h42);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
